aximm_follower_app: RTL and testbench
=====================================

Name: aximm_follower_app

Overview:
- AXI4-MM follower-side application endpoint; terminates the user AW/W/B/AR/R channels driven by the leader application across the AIB link.
- Stores write bursts in an internal byte-enabled memory and returns B responses.
- Serves read bursts from the same memory, so write-then-read loopback tests can check data end to end.
- Exposes burst counters and a sticky length-error flag for the test harness.

Parameters:
DWIDTH, 128, data bus width in bits; one beat = DWIDTH/8 bytes
ADDRWIDTH, 32, byte address width
MEM_DEPTH, 256, memory entries of DWIDTH bits; power of two

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- user_awid/awsize/awlen/awburst/awaddr  in  4/3/8/2/ADDRWIDTH  write address fields
- user_awvalid in 1; user_awready out 1
- user_wid/wdata/wstrb/wlast  in  4/DWIDTH/DWIDTH/8/1  write data fields
- user_wvalid in 1; user_wready out 1
- user_bid out 4; user_bresp out 2; user_bvalid out 1; user_bready in 1
- user_arid/arsize/arlen/arburst/araddr  in  4/3/8/2/ADDRWIDTH  read address fields
- user_arvalid in 1; user_arready out 1
- user_rid out 4; user_rdata out DWIDTH; user_rresp out 2; user_rlast out 1; user_rvalid out 1; user_rready in 1
- wr_burst_cnt  out 16  completed write bursts (B handshakes), wraps at 2^16
- rd_burst_cnt  out 16  completed read bursts (rlast handshakes), wraps at 2^16
- wr_len_err    out 1   sticky: a write beat count differed from awlen+1

Behaviour:
- Reset values: awready=1, arready=1; all other channel outputs 0; counters 0; wr_len_err 0.
- Reset is asynchronous: asserting rst mid-burst forces both FSMs to idle immediately. The in-flight burst is discarded with no B response and no further R beats. Memory contents are not reset.
- Address and length: entry index = addr >> log2(DWIDTH/8), modulo MEM_DEPTH. Pointer increments by 1 per beat and wraps MEM_DEPTH-1 -> 0. axsize and axburst are ignored; every burst is treated as INCR with a full-width beat. Burst length = axlen+1 beats.
- Write FSM, WR_IDLE -> WR_DATA -> WR_RESP:
  - WR_IDLE: awready=1. On awvalid&awready, latch awid, awlen and index; clear the beat counter; go to WR_DATA with awready=0.
  - WR_DATA: wready=1. Each wvalid&wready writes wdata to mem[ptr] under wstrb byte enables, then ptr++ and beat_cnt++. The beat with wlast ends the burst; go to WR_RESP.
  - End-of-burst check: if beats (including the wlast beat) != awlen+1, bresp=2'b10 (SLVERR) and wr_len_err is set; otherwise bresp=2'b00. Beats beyond awlen+1 without wlast are still written (the pointer wraps).
  - WR_RESP: bvalid=1 from the cycle after the wlast handshake. bid = latched awid. Hold until bready; on the handshake, increment wr_burst_cnt and return to WR_IDLE, where awready=1 on the next cycle.
- Read FSM, RD_IDLE -> RD_DATA:
  - RD_IDLE: arready=1. On arvalid&arready, latch arid, arlen and index; go to RD_DATA.
  - RD_DATA: rvalid=1 starting the cycle after the AR handshake; rdata is a registered read of mem[ptr].
  - rdata, rlast and rid are held stable while rvalid&!rready.
  - On each rvalid&rready the next beat is loaded, so back-to-back beats need no bubble.
  - rlast=1 on beat arlen (0-based). The rlast handshake drops rvalid, increments rd_burst_cnt and returns to RD_IDLE.
  - rresp is always 2'b00.
- Concurrency: the write and read FSMs are fully independent. A same-cycle write and read-load of the same entry returns the old data.
- awlen=0 / arlen=0: single-beat burst; wlast/rlast apply to the first beat.
- Transfer IDs are echoed only; there is no reordering and at most one outstanding burst per direction.

Decomposition:
- Shared package aximm_follower_pkg holds:
  - write state encodings and read state encodings
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_INCR=2'b01
  - function for the beat-byte shift
- One sub-module, aximm_follower_mem: one write port with byte enables, one registered read port, MEM_DEPTH x DWIDTH.

Test Plan:
- Basic write: awaddr 0x0, awlen 3, four beats 0x1..0x4, wlast on beat 4 -> bvalid the next cycle, bresp 00, bid=awid, wr_burst_cnt=1, mem[0..3]=1..4.
- Read back with throttling: araddr 0x0, arlen 3, rready toggled 1/0 -> rdata 1,2,3,4 held stable while stalled, rlast only on the 4th beat, rd_burst_cnt=1, arready high again after the rlast handshake.
- Short write: awlen 3 with wlast on beat 3 -> bresp 10, wr_len_err=1 and stays 1 through a following good burst.
- Wrap, MEM_DEPTH=256: awaddr 0xFF0, awlen 1, data A,B -> entries 255 and 0; a read at 0xFF0 returns A,B.
- Partial strobe: wstrb 16'h00FF, wdata all-ones over an entry of zeros -> entry reads back 0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF.
- Reset mid-read (rst asserted on beat 2 of 4) -> rvalid=0 immediately; after release arready=1, counters 0, and memory data is preserved on re-read.

Source files
------------

// File: rtl/aximm_follower_pkg.sv
// Shared encodings and helpers for the AXI4-MM follower application endpoint.
// Both FSMs use plain 2-bit localparam codes so the debug outputs are stable.
package aximm_follower_pkg;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_DATA = 2'd1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Right-shift that turns a byte address into a full-beat entry index.
  function automatic int beat_shift(input int dwidth);
    return $clog2(dwidth / 8);
  endfunction

endpackage

// File: rtl/aximm_follower_app_if.sv
// User-side AXI4-MM channel bundle between the leader application and the follower endpoint.
// Every channel transfers on the rising clk edge where valid and ready are both high; valid never waits for ready.
interface aximm_follower_app_if #(
  parameter int DWIDTH    = 128,
  parameter int ADDRWIDTH = 32
);

  logic [3:0]           user_awid;
  logic [2:0]           user_awsize;
  logic [7:0]           user_awlen;
  logic [1:0]           user_awburst;
  logic [ADDRWIDTH-1:0] user_awaddr;
  logic                 user_awvalid;
  logic                 user_awready;

  logic [3:0]           user_wid;
  logic [DWIDTH-1:0]    user_wdata;
  logic [DWIDTH/8-1:0]  user_wstrb;
  logic                 user_wlast;
  logic                 user_wvalid;
  logic                 user_wready;

  logic [3:0]           user_bid;
  logic [1:0]           user_bresp;
  logic                 user_bvalid;
  logic                 user_bready;

  logic [3:0]           user_arid;
  logic [2:0]           user_arsize;
  logic [7:0]           user_arlen;
  logic [1:0]           user_arburst;
  logic [ADDRWIDTH-1:0] user_araddr;
  logic                 user_arvalid;
  logic                 user_arready;

  logic [3:0]           user_rid;
  logic [DWIDTH-1:0]    user_rdata;
  logic [1:0]           user_rresp;
  logic                 user_rlast;
  logic                 user_rvalid;
  logic                 user_rready;

  modport master (
    output user_awid, user_awsize, user_awlen, user_awburst, user_awaddr, user_awvalid,
    input  user_awready,
    output user_wid, user_wdata, user_wstrb, user_wlast, user_wvalid,
    input  user_wready,
    input  user_bid, user_bresp, user_bvalid,
    output user_bready,
    output user_arid, user_arsize, user_arlen, user_arburst, user_araddr, user_arvalid,
    input  user_arready,
    input  user_rid, user_rdata, user_rresp, user_rlast, user_rvalid,
    output user_rready
  );

  modport slave (
    input  user_awid, user_awsize, user_awlen, user_awburst, user_awaddr, user_awvalid,
    output user_awready,
    input  user_wid, user_wdata, user_wstrb, user_wlast, user_wvalid,
    output user_wready,
    output user_bid, user_bresp, user_bvalid,
    input  user_bready,
    input  user_arid, user_arsize, user_arlen, user_arburst, user_araddr, user_arvalid,
    output user_arready,
    output user_rid, user_rdata, user_rresp, user_rlast, user_rvalid,
    input  user_rready
  );

endinterface

// File: rtl/aximm_follower_mem.sv
// MEM_DEPTH x DWIDTH storage: one byte-enabled write port, one registered read port.
// Contents are never reset; only the read register is, so rdata is zero out of reset.
module aximm_follower_mem #(
  parameter int DWIDTH    = 128,
  parameter int MEM_DEPTH = 256,
  parameter int IDXW      = $clog2(MEM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [IDXW-1:0]     wr_idx_i,
  input  logic [DWIDTH-1:0]   wr_data_i,
  input  logic [DWIDTH/8-1:0] wr_be_i,
  input  logic                rd_en_i,
  input  logic [IDXW-1:0]     rd_idx_i,
  output logic [DWIDTH-1:0]   rd_data_o
);

  logic [DWIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DWIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < DWIDTH / 8; b++) begin
      if (wr_en_i && wr_be_i[b]) mem_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
    end
  end

  // A same-edge write to rd_idx_i is not visible here: the old word is returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_idx_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/aximm_follower_app.sv
// Follower-side AXI4-MM endpoint: stores write bursts in local memory, answers B, serves read bursts.
// Write and read paths are independent FSMs sharing only the memory.
module aximm_follower_app
  import aximm_follower_pkg::*;
#(
  parameter int DWIDTH    = 128,
  parameter int ADDRWIDTH = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  aximm_follower_app_if.slave  axi,
  output logic [15:0]          wr_burst_cnt,
  output logic [15:0]          rd_burst_cnt,
  output logic                 wr_len_err,
  output logic [1:0]           dbg_wr_state_o,
  output logic [1:0]           dbg_rd_state_o
);

  localparam int IDXW   = $clog2(MEM_DEPTH);
  localparam int BSHIFT = beat_shift(DWIDTH);

  logic [ADDRWIDTH-1:0] aw_sh, ar_sh;
  logic [IDXW-1:0]      aw_idx, ar_idx;

  assign aw_sh  = axi.user_awaddr >> BSHIFT;
  assign ar_sh  = axi.user_araddr >> BSHIFT;
  assign aw_idx = aw_sh[IDXW-1:0];
  assign ar_idx = ar_sh[IDXW-1:0];

  // Size and burst type are accepted but every burst is full-width INCR.
  logic unused_ok;
  assign unused_ok = ^{axi.user_awsize, axi.user_awburst, axi.user_wid,
                       axi.user_arsize, axi.user_arburst, aw_sh, ar_sh};

  // ---------------- write path ----------------
  logic [1:0]      wr_state_q, wr_state_d;
  logic [3:0]      awid_q, awid_d;
  logic [7:0]      awlen_q, awlen_d;
  logic [IDXW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]      wr_beat_q, wr_beat_d;
  logic            wr_over_q, wr_over_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [15:0]     wr_cnt_q, wr_cnt_d;
  logic            len_err_q, len_err_d;
  logic            w_fire;

  assign w_fire = (wr_state_q == WR_DATA) && axi.user_wvalid;

  always_comb begin
    wr_state_d = wr_state_q;
    awid_d     = awid_q;
    awlen_d    = awlen_q;
    wr_ptr_d   = wr_ptr_q;
    wr_beat_d  = wr_beat_q;
    wr_over_d  = wr_over_q;
    bresp_d    = bresp_q;
    wr_cnt_d   = wr_cnt_q;
    len_err_d  = len_err_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (axi.user_awvalid) begin
          awid_d     = axi.user_awid;
          awlen_d    = axi.user_awlen;
          wr_ptr_d   = aw_idx;
          wr_beat_d  = '0;
          wr_over_d  = 1'b0;
          wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (axi.user_wvalid) begin
          wr_ptr_d  = wr_ptr_q + IDXW'(1);
          wr_beat_d = wr_beat_q + 8'd1;
          if (axi.user_wlast) begin
            // wr_over_q covers bursts that ran past awlen+1 and let the 8-bit counter wrap.
            if (wr_over_q || (wr_beat_q != awlen_q)) begin
              bresp_d   = RESP_SLVERR;
              len_err_d = 1'b1;
            end else begin
              bresp_d   = RESP_OKAY;
            end
            wr_state_d = WR_RESP;
          end else if (wr_beat_q == awlen_q) begin
            wr_over_d = 1'b1;
          end
        end
      end
      WR_RESP: begin
        if (axi.user_bready) begin
          wr_cnt_d   = wr_cnt_q + 16'd1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      awid_q     <= '0;
      awlen_q    <= '0;
      wr_ptr_q   <= '0;
      wr_beat_q  <= '0;
      wr_over_q  <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_cnt_q   <= '0;
      len_err_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      awid_q     <= awid_d;
      awlen_q    <= awlen_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_beat_q  <= wr_beat_d;
      wr_over_q  <= wr_over_d;
      bresp_q    <= bresp_d;
      wr_cnt_q   <= wr_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  // ---------------- read path ----------------
  logic [1:0]      rd_state_q, rd_state_d;
  logic [3:0]      arid_q, arid_d;
  logic [7:0]      arlen_q, arlen_d;
  logic [IDXW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]      rd_beat_q, rd_beat_d;
  logic [15:0]     rd_cnt_q, rd_cnt_d;
  logic            rd_last, rd_en;
  logic [IDXW-1:0] rd_idx;

  assign rd_last = (rd_beat_q == arlen_q);
  // rd_ptr_q names the entry on the bus; the next beat is prefetched on the accepting edge.
  assign rd_en   = ((rd_state_q == RD_IDLE) && axi.user_arvalid) ||
                   ((rd_state_q == RD_DATA) && axi.user_rready && !rd_last);
  assign rd_idx  = (rd_state_q == RD_IDLE) ? ar_idx : rd_ptr_q + IDXW'(1);

  always_comb begin
    rd_state_d = rd_state_q;
    arid_d     = arid_q;
    arlen_d    = arlen_q;
    rd_ptr_d   = rd_ptr_q;
    rd_beat_d  = rd_beat_q;
    rd_cnt_d   = rd_cnt_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (axi.user_arvalid) begin
          arid_d     = axi.user_arid;
          arlen_d    = axi.user_arlen;
          rd_ptr_d   = ar_idx;
          rd_beat_d  = '0;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axi.user_rready) begin
          if (rd_last) begin
            rd_cnt_d   = rd_cnt_q + 16'd1;
            rd_state_d = RD_IDLE;
          end else begin
            rd_ptr_d   = rd_ptr_q + IDXW'(1);
            rd_beat_d  = rd_beat_q + 8'd1;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      arid_q     <= '0;
      arlen_q    <= '0;
      rd_ptr_q   <= '0;
      rd_beat_q  <= '0;
      rd_cnt_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arid_q     <= arid_d;
      arlen_q    <= arlen_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_beat_q  <= rd_beat_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  aximm_follower_mem #(
    .DWIDTH    (DWIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .IDXW      (IDXW)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (w_fire),
    .wr_idx_i  (wr_ptr_q),
    .wr_data_i (axi.user_wdata),
    .wr_be_i   (axi.user_wstrb),
    .rd_en_i   (rd_en),
    .rd_idx_i  (rd_idx),
    .rd_data_o (axi.user_rdata)
  );

  assign axi.user_awready = (wr_state_q == WR_IDLE);
  assign axi.user_wready  = (wr_state_q == WR_DATA);
  assign axi.user_bvalid  = (wr_state_q == WR_RESP);
  assign axi.user_bid     = awid_q;
  assign axi.user_bresp   = bresp_q;

  assign axi.user_arready = (rd_state_q == RD_IDLE);
  assign axi.user_rvalid  = (rd_state_q == RD_DATA);
  assign axi.user_rlast   = (rd_state_q == RD_DATA) && rd_last;
  assign axi.user_rid     = arid_q;
  assign axi.user_rresp   = RESP_OKAY;

  assign wr_burst_cnt   = wr_cnt_q;
  assign rd_burst_cnt   = rd_cnt_q;
  assign wr_len_err     = len_err_q;
  assign dbg_wr_state_o = wr_state_q;
  assign dbg_rd_state_o = rd_state_q;

endmodule

// File: tb/tb_aximm_follower_app.sv
// Bench for aximm_follower_app: drives bursts, keeps a reference memory, scoreboards B and R channels.
module tb_aximm_follower_app;
  import aximm_follower_pkg::*;

  localparam int DW    = 128;
  localparam int AW    = 32;
  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aximm_follower_app_if #(.DWIDTH(DW), .ADDRWIDTH(AW)) axi ();

  logic [15:0] wr_burst_cnt, rd_burst_cnt;
  logic        wr_len_err;
  logic [1:0]  dbg_wr_state, dbg_rd_state;

  aximm_follower_app #(.DWIDTH(DW), .ADDRWIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .axi            (axi),
    .wr_burst_cnt   (wr_burst_cnt),
    .rd_burst_cnt   (rd_burst_cnt),
    .wr_len_err     (wr_len_err),
    .dbg_wr_state_o (dbg_wr_state),
    .dbg_rd_state_o (dbg_rd_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [3:0]    bid_exp_q[$];
  logic [1:0]    bresp_exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] bd [16];
  logic [15:0]   bs [16];
  int            exp_wr_cnt = 0;
  int            exp_rd_cnt = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input int nbeats, input int bdelay);
    int   idx;
    logic done;
    logic [3:0] got_bid;
    logic [1:0] got_bresp;
    idx = int'(addr[11:4]);
    bid_exp_q.push_back(id);
    bresp_exp_q.push_back((nbeats == int'(len) + 1) ? RESP_OKAY : RESP_SLVERR);

    axi.user_awid    = id;
    axi.user_awaddr  = addr;
    axi.user_awlen   = len;
    axi.user_awsize  = 3'd4;
    axi.user_awburst = BURST_INCR;
    axi.user_awvalid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      done = axi.user_awready;
      tick();
    end
    axi.user_awvalid = 1'b0;
    check_val("aw_handshake", done, 1'b1);
    check_val("awready_busy", axi.user_awready, 1'b0);

    for (int b = 0; b < nbeats; b++) begin
      axi.user_wid    = id;
      axi.user_wdata  = bd[b];
      axi.user_wstrb  = bs[b];
      axi.user_wlast  = (b == nbeats - 1);
      axi.user_wvalid = 1'b1;
      done = 1'b0;
      for (int n = 0; n < 50 && !done; n++) begin
        done = axi.user_wready;
        tick();
      end
      if (done) begin
        for (int k = 0; k < DW / 8; k++)
          if (bs[b][k]) model_mem[idx][k*8 +: 8] = bd[b][k*8 +: 8];
        idx = (idx + 1) % DEPTH;
      end
    end
    axi.user_wvalid = 1'b0;
    axi.user_wlast  = 1'b0;
    check_val("bvalid_next_cycle", axi.user_bvalid, 1'b1);

    repeat (bdelay) tick();
    axi.user_bready = 1'b1;
    done = 1'b0;
    got_bid = '0;
    got_bresp = '0;
    for (int n = 0; n < 50 && !done; n++) begin
      done = axi.user_bvalid;
      got_bid = axi.user_bid;
      got_bresp = axi.user_bresp;
      tick();
    end
    axi.user_bready = 1'b0;
    check_val("b_handshake", done, 1'b1);
    check_val("bid", got_bid, bid_exp_q.pop_front());
    check_val("bresp", got_bresp, bresp_exp_q.pop_front());
    exp_wr_cnt++;
    check_val("bvalid_drop", axi.user_bvalid, 1'b0);
    check_val("awready_back", axi.user_awready, 1'b1);
    check_val("wr_burst_cnt", wr_burst_cnt, 16'(exp_wr_cnt));
  endtask

  // mode 0: rready always high, 1: toggling 1/0, 2: random. abort_at >= 0 resets on that beat.
  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input int mode, input int abort_at);
    int   idx;
    int   beat;
    logic done, stalled, aborted;
    logic [DW-1:0] held_data;
    logic held_last;
    idx = int'(addr[11:4]);
    for (int b = 0; b <= int'(len); b++) exp_q.push_back(model_mem[(idx + b) % DEPTH]);

    axi.user_arid    = id;
    axi.user_araddr  = addr;
    axi.user_arlen   = len;
    axi.user_arsize  = 3'd4;
    axi.user_arburst = BURST_INCR;
    axi.user_arvalid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      done = axi.user_arready;
      tick();
    end
    axi.user_arvalid = 1'b0;
    check_val("ar_handshake", done, 1'b1);
    check_val("rvalid_next_cycle", axi.user_rvalid, 1'b1);
    check_val("arready_busy", axi.user_arready, 1'b0);

    beat = 0;
    stalled = 1'b0;
    aborted = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    for (int cyc = 0; cyc < 300 && beat <= int'(len) && !aborted; cyc++) begin
      if (beat == abort_at) begin
        axi.user_rready = 1'b0;
        rst = 1'b1;
        #1;
        check_val("rvalid_async_reset", axi.user_rvalid, 1'b0);
        check_val("rlast_async_reset", axi.user_rlast, 1'b0);
        exp_q.delete();
        aborted = 1'b1;
      end else begin
        case (mode)
          0:       axi.user_rready = 1'b1;
          1:       axi.user_rready = (cyc % 2 == 0);
          default: axi.user_rready = 1'($urandom_range(0, 1));
        endcase
        check_val("rvalid_in_burst", axi.user_rvalid, 1'b1);
        if (stalled) begin
          check_val("rdata_held", axi.user_rdata, held_data);
          check_val("rlast_held", axi.user_rlast, held_last);
        end
        if (axi.user_rready) begin
          check_val("rdata", axi.user_rdata, exp_q.pop_front());
          check_val("rlast", axi.user_rlast, beat == int'(len));
          check_val("rid", axi.user_rid, id);
          check_val("rresp", axi.user_rresp, RESP_OKAY);
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_data = axi.user_rdata;
          held_last = axi.user_rlast;
        end
        tick();
      end
    end
    axi.user_rready = 1'b0;
    if (!aborted) begin
      check_val("r_beats", beat, int'(len) + 1);
      exp_rd_cnt++;
      check_val("rvalid_drop", axi.user_rvalid, 1'b0);
      check_val("arready_back", axi.user_arready, 1'b1);
      check_val("rd_burst_cnt", rd_burst_cnt, 16'(exp_rd_cnt));
    end
  endtask

  task automatic fill_random(input int n, input logic full_strobe);
    for (int b = 0; b < n; b++) begin
      bd[b] = {$urandom, $urandom, $urandom, $urandom};
      bs[b] = full_strobe ? 16'hFFFF : 16'($urandom_range(0, 65535));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] raddr;
    logic [7:0]  rlen;
    axi.user_awid = '0; axi.user_awsize = '0; axi.user_awlen = '0; axi.user_awburst = '0;
    axi.user_awaddr = '0; axi.user_awvalid = 1'b0;
    axi.user_wid = '0; axi.user_wdata = '0; axi.user_wstrb = '0; axi.user_wlast = 1'b0;
    axi.user_wvalid = 1'b0; axi.user_bready = 1'b0;
    axi.user_arid = '0; axi.user_arsize = '0; axi.user_arlen = '0; axi.user_arburst = '0;
    axi.user_araddr = '0; axi.user_arvalid = 1'b0; axi.user_rready = 1'b0;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    check_val("rst_awready", axi.user_awready, 1'b1);
    check_val("rst_arready", axi.user_arready, 1'b1);
    check_val("rst_wready", axi.user_wready, 1'b0);
    check_val("rst_bvalid", axi.user_bvalid, 1'b0);
    check_val("rst_rvalid", axi.user_rvalid, 1'b0);
    check_val("rst_rlast", axi.user_rlast, 1'b0);
    check_val("rst_rdata", axi.user_rdata, '0);
    check_val("rst_bid", axi.user_bid, 4'd0);
    check_val("rst_wr_cnt", wr_burst_cnt, 16'd0);
    check_val("rst_rd_cnt", rd_burst_cnt, 16'd0);
    check_val("rst_len_err", wr_len_err, 1'b0);
    check_val("rst_wr_state", dbg_wr_state, WR_IDLE);

    // Basic four-beat write, then throttled read-back.
    for (int b = 0; b < 4; b++) begin bd[b] = DW'(b + 1); bs[b] = 16'hFFFF; end
    wr_burst(4'd5, 32'h0, 8'd3, 4, 0);
    check_val("len_err_after_good", wr_len_err, 1'b0);
    rd_burst(4'd9, 32'h0, 8'd3, 1, -1);

    // Short burst flags SLVERR; the sticky error survives a later good burst.
    fill_random(3, 1'b1);
    wr_burst(4'd2, 32'h100, 8'd3, 3, 1);
    check_val("len_err_short", wr_len_err, 1'b1);
    fill_random(2, 1'b1);
    wr_burst(4'd3, 32'h140, 8'd1, 2, 0);
    check_val("len_err_sticky", wr_len_err, 1'b1);
    rd_burst(4'd4, 32'h100, 8'd2, 0, -1);

    // Over-length burst: extra beats still land in memory.
    fill_random(3, 1'b1);
    wr_burst(4'd6, 32'h200, 8'd1, 3, 2);
    rd_burst(4'd6, 32'h200, 8'd2, 2, -1);

    // Pointer wrap from entry 255 to entry 0.
    bd[0] = {4{32'hAAAA_0001}}; bd[1] = {4{32'hBBBB_0002}}; bs[0] = 16'hFFFF; bs[1] = 16'hFFFF;
    wr_burst(4'd7, 32'hFF0, 8'd1, 2, 0);
    rd_burst(4'd8, 32'hFF0, 8'd1, 1, -1);
    rd_burst(4'd8, 32'h0, 8'd0, 0, -1);

    // Low-half strobe over a zeroed entry.
    bd[0] = '0; bs[0] = 16'hFFFF;
    wr_burst(4'd1, 32'h400, 8'd0, 1, 0);
    bd[0] = '1; bs[0] = 16'h00FF;
    wr_burst(4'd1, 32'h400, 8'd0, 1, 0);
    rd_burst(4'd1, 32'h400, 8'd0, 0, -1);

    // Randomised bursts: full-strobe base, random-strobe overlay, random read throttling.
    for (int it = 0; it < 6; it++) begin
      raddr = {20'h0, 8'($urandom_range(0, 255)), 4'h0};
      rlen  = 8'($urandom_range(0, 7));
      fill_random(int'(rlen) + 1, 1'b1);
      wr_burst(4'($urandom_range(0, 15)), raddr, rlen, int'(rlen) + 1, $urandom_range(0, 2));
      fill_random(int'(rlen) + 1, 1'b0);
      wr_burst(4'($urandom_range(0, 15)), raddr, rlen, int'(rlen) + 1, $urandom_range(0, 2));
      rd_burst(4'($urandom_range(0, 15)), raddr, rlen, 2, -1);
    end

    // Reset on the second beat of a four-beat read; memory must survive.
    rd_burst(4'd3, 32'h0, 8'd3, 0, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_wr_cnt = 0;
    exp_rd_cnt = 0;
    tick();
    check_val("post_rst_arready", axi.user_arready, 1'b1);
    check_val("post_rst_rvalid", axi.user_rvalid, 1'b0);
    check_val("post_rst_wr_cnt", wr_burst_cnt, 16'd0);
    check_val("post_rst_rd_cnt", rd_burst_cnt, 16'd0);
    check_val("post_rst_len_err", wr_len_err, 1'b0);
    rd_burst(4'd3, 32'h0, 8'd3, 1, -1);

    check_val("exp_q_drained", DW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
